// File: rtl/pinst_dispatch.sv
// pinst_dispatch: instruction FIFO and one-at-a-time issue stage toward the array controller,
// with a watchdog that flags a controller that never signals completion.
module pinst_dispatch #(
    parameter int INST_W = 64,
    parameter int DEPTH  = 4,
    parameter int TO_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INST_W-1:0]          in_inst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [INST_W-1:0]          inst,
    output logic                       load,
    input  logic                       next,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [INST_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;
    logic [INST_W-1:0]   inst_q;
    logic                load_q;
    logic [TO_W-1:0]     wdog_q, wdog_d;
    logic                err_q, err_d;
    logic                push, issue;

    // ready looks only at the registered count, so a full FIFO stays blocked during its pop cycle
    assign in_ready = (cnt_q != CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign issue    = (state_q == IDLE) && (cnt_q != '0) && !flush;

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (issue) begin
                state_d = WAIT;
                wdog_d  = '0;
            end
        end else if (next) begin
            state_d = IDLE;
        end else if (wdog_q == '1) begin
            state_d = IDLE;
            err_d   = 1'b1;
            wdog_d  = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            inst_q  <= '0;
            load_q  <= 1'b0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            load_q  <= issue;
            if (issue) inst_q <= mem_q[rd_q];
            if (push) wr_q <= wr_q + 1'b1;
            if (flush) begin
                cnt_q <= '0;
                rd_q  <= wr_q;
            end else begin
                cnt_q <= cnt_q + CW'(push) - CW'(issue);
                rd_q  <= rd_q + AW'(issue);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_inst;
    end

    assign inst        = inst_q;
    assign load        = load_q;
    assign busy        = (state_q == WAIT);
    assign count       = cnt_q;
    assign timeout_err = err_q;
endmodule
